uart_boot_loader_ctrl: RTL and testbench

UART_BOOT_LOADER_CTRL -- requirements
Module: uart_boot_loader_ctrl

---
 rtl/uart_boot_loader_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_boot_loader_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader_ctrl.sv
// UART boot loader: handshake, address/length header, payload written as 32-bit words, Adler-32 check.
// Single clock; mem_we held until mem_ack; tx_valid held until tx_ready; timeout and overrun abort the session.
module uart_boot_loader_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [16:0] ADLER_MOD = 17'd65521;

  typedef enum logic [3:0] {
    IDLE, ECHO_C, WAIT_S, WAIT_CMD, ADDR, LEN, PAYLOAD, FLUSH, CSUM, RESP
  } state_t;

  state_t      state, nxt;
  logic [TW-1:0] timer;
  logic [1:0]  sub_cnt;
  logic [15:0] pay_cnt, len, word_idx;
  logic [31:0] base, csum, asm_word;
  logic [3:0]  asm_strb;
  logic [15:0] s1, s2;
  logic        match;

  logic        tx_hs, timed, timeout, last, word_done, wr_busy, abort;
  logic [1:0]  lane;
  logic [31:0] asm_nxt;
  logic [3:0]  strb_nxt;
  logic [16:0] s1_sum, s2_sum;
  logic [15:0] s1_new, s2_new;
  logic [15:0] len_full;

  always_comb begin
    tx_hs     = tx_valid && tx_ready;
    timed     = (state != IDLE) && (state != ECHO_C) && (state != RESP);
    timeout   = timed && !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
    lane      = pay_cnt[1:0];
    last      = (pay_cnt == len - 16'd1);
    word_done = (state == PAYLOAD) && rx_valid && ((lane == 2'd3) || last);
    // A write acked this very edge frees the write register for the next word.
    wr_busy   = mem_we && !mem_ack;
    asm_nxt   = asm_word | ({24'b0, rx_data} << {lane, 3'b000});
    strb_nxt  = asm_strb | (4'b0001 << lane);
    s1_sum    = {1'b0, s1} + {9'b0, rx_data};
    s1_new    = (s1_sum >= ADLER_MOD) ? 16'(s1_sum - ADLER_MOD) : s1_sum[15:0];
    s2_sum    = {1'b0, s2} + {1'b0, s1_new};
    s2_new    = (s2_sum >= ADLER_MOD) ? 16'(s2_sum - ADLER_MOD) : s2_sum[15:0];
    len_full  = {rx_data, len[15:8]};
  end

  always_comb begin
    nxt      = state;
    abort    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      IDLE:     if (rx_valid && rx_data == 8'h43) nxt = ECHO_C;
      ECHO_C: begin
        tx_valid = 1'b1;
        tx_data  = 8'h43;
        if (tx_hs) nxt = WAIT_S;
      end
      WAIT_S:   if (rx_valid) begin
        if (rx_data == 8'h53) nxt = WAIT_CMD;
        else abort = 1'b1;
      end
      WAIT_CMD: if (rx_valid) begin
        if (rx_data == 8'h55) nxt = ADDR;
        else abort = 1'b1;
      end
      ADDR:     if (rx_valid && sub_cnt == 2'd3) nxt = LEN;
      LEN:      if (rx_valid && sub_cnt == 2'd1) nxt = (len_full == 16'd0) ? CSUM : PAYLOAD;
      PAYLOAD:  if (rx_valid) begin
        if (word_done && wr_busy) abort = 1'b1;
        else if (last) nxt = FLUSH;
      end
      FLUSH:    if (!wr_busy) nxt = CSUM;
      CSUM:     if (rx_valid && sub_cnt == 2'd3) nxt = RESP;
      RESP: begin
        tx_valid = 1'b1;
        tx_data  = match ? 8'h4F : 8'h4E;
        if (tx_hs) nxt = IDLE;
      end
      default:  nxt = IDLE;
    endcase
    if (timeout) abort = 1'b1;
    if (abort) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      sub_cnt   <= '0;
      pay_cnt   <= '0;
      len       <= '0;
      word_idx  <= '0;
      base      <= '0;
      csum      <= '0;
      asm_word  <= '0;
      asm_strb  <= '0;
      s1        <= 16'd1;
      s2        <= 16'd0;
      match     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      mem_we    <= 1'b0;
      core_hold <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nxt;
      done  <= 1'b0;
      err   <= abort;
      if (!timed || rx_valid || abort) timer <= '0;
      else timer <= timer + TW'(1);
      if (mem_we && mem_ack) mem_we <= 1'b0;

      if (abort) begin
        mem_we    <= 1'b0;
        core_hold <= 1'b0;
      end else begin
        case (state)
          IDLE: if (rx_valid && rx_data == 8'h43) begin
            sub_cnt  <= '0;
            pay_cnt  <= '0;
            word_idx <= '0;
            asm_word <= '0;
            asm_strb <= '0;
            s1       <= 16'd1;
            s2       <= 16'd0;
          end
          WAIT_S: if (rx_valid) core_hold <= 1'b1;
          ADDR: if (rx_valid) begin
            sub_cnt <= sub_cnt + 2'd1;
            if (sub_cnt == 2'd3) base <= {base[23:0], rx_data[7:2], 2'b00};
            else base <= {base[23:0], rx_data};
          end
          LEN: if (rx_valid) begin
            len     <= len_full;
            sub_cnt <= (sub_cnt == 2'd1) ? 2'd0 : sub_cnt + 2'd1;
          end
          PAYLOAD: if (rx_valid) begin
            s1      <= s1_new;
            s2      <= s2_new;
            pay_cnt <= pay_cnt + 16'd1;
            if (word_done) begin
              mem_we    <= 1'b1;
              mem_addr  <= base + {14'b0, word_idx, 2'b00};
              mem_wdata <= asm_nxt;
              mem_wstrb <= strb_nxt;
              asm_word  <= '0;
              asm_strb  <= '0;
              word_idx  <= word_idx + 16'd1;
            end else begin
              asm_word <= asm_nxt;
              asm_strb <= strb_nxt;
            end
          end
          CSUM: if (rx_valid) begin
            csum    <= {rx_data, csum[31:8]};
            sub_cnt <= sub_cnt + 2'd1;
            if (sub_cnt == 2'd3) match <= ({rx_data, csum[31:8]} == {s2, s1});
          end
          RESP: if (tx_hs) begin
            core_hold <= 1'b0;
            done      <= match;
            err       <= !match;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// Randomized bench for uart_boot_loader_ctrl against a queue-based upload/Adler-32 model.
module tb_uart_boot_loader_ctrl;
  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_we, mem_ack, core_hold, done, err;

  uart_boot_loader_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_we(mem_we), .mem_ack(mem_ack), .core_hold(core_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  int   n_chk = 0, n_fail = 0;
  int   done_cnt = 0, err_cnt = 0;
  logic [7:0] txq[$];
  wr_t  wq[$];
  logic [7:0] pay_q[$];
  bit   ack_en = 1'b1;
  int   ack_dly = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter and memory responders with random stalls.
  initial begin
    mem_ack  = 1'b0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 3) != 0);
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_we && ack_en && !reset) begin
        if (ack_dly == 0) begin
          mem_ack = 1'b1;
          ack_dly = $urandom_range(0, 3);
        end else ack_dly--;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (mem_we && mem_ack) wq.push_back('{mem_addr, mem_wdata, mem_wstrb});
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = $urandom;
    repeat ($urandom_range(0, 4)) @(posedge clk);
  endtask

  task automatic wait_tx(input int n, input string tag);
    for (int i = 0; i < 300 && txq.size() < n; i++) cyc(1);
    chk(tag, txq.size() >= n, 1);
  endtask

  task automatic wait_mem_idle();
    for (int i = 0; i < 50 && mem_we; i++) cyc(1);
  endtask

  task automatic header(input logic [31:0] base, input logic [15:0] n, input string tag, output int t0);
    t0 = txq.size();
    send(8'h43);
    wait_tx(t0 + 1, {tag, "_echo_wait"});
    chk({tag, "_echo"}, txq[t0], 8'h43);
    send(8'h53);
    send(8'h55);
    chk({tag, "_hold"}, core_hold, 1);
    for (int i = 3; i >= 0; i--) send(base[8*i +: 8]);
    send(n[7:0]);
    send(n[15:8]);
  endtask

  // Full upload of pay_q; expected writes and checksum derived from first principles.
  task automatic session(input logic [31:0] base, input bit bad, input string tag);
    int t0, w0, d0, e0, n, nw;
    int unsigned a1, a2;
    logic [31:0] cs;
    wr_t exp_w[$];
    n  = pay_q.size();
    w0 = wq.size();
    d0 = done_cnt;
    e0 = err_cnt;
    a1 = 1;
    a2 = 0;
    foreach (pay_q[i]) begin
      a1 = (a1 + pay_q[i]) % 65521;
      a2 = (a2 + a1) % 65521;
    end
    cs = {a2[15:0], a1[15:0]};
    if (bad) cs = cs ^ (32'h1 << $urandom_range(0, 31));
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      wr_t x;
      x.addr = (base & 32'hFFFF_FFFC) + 32'(4 * w);
      x.data = '0;
      x.strb = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) begin
          x.data[8*k +: 8] = pay_q[4*w + k];
          x.strb[k] = 1'b1;
        end
      exp_w.push_back(x);
    end
    header(base, 16'(n), tag, t0);
    foreach (pay_q[i]) send(pay_q[i]);
    wait_mem_idle();
    for (int i = 0; i < 4; i++) send(cs[8*i +: 8]);
    wait_tx(t0 + 2, {tag, "_resp_wait"});
    cyc(3);
    chk({tag, "_resp"}, txq[t0 + 1], bad ? 8'h4E : 8'h4F);
    chk({tag, "_done"}, done_cnt - d0, bad ? 0 : 1);
    chk({tag, "_err"}, err_cnt - e0, bad ? 1 : 0);
    chk({tag, "_nwr"}, wq.size() - w0, nw);
    foreach (exp_w[w]) chk({tag, "_wr"}, wq[w0 + w], exp_w[w]);
    chk({tag, "_hold_clr"}, core_hold, 0);
  endtask

  initial begin
    int t0, e0, w0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cyc(3);
    chk("rst_txv", tx_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_hold", core_hold, 0);
    chk("rst_pulses", {done, err}, 0);
    chk("rst_mem", {mem_addr, mem_wdata, mem_wstrb}, 0);
    reset = 1'b0;
    cyc(2);

    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    session(32'h8000_0000, 1'b0, "full4");
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    session(32'h8000_0000, 1'b0, "pay6");
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    session(32'h8000_0000, 1'b1, "badcs");
    pay_q = {};
    session(32'h1234_5678, 1'b0, "len0");

    // Bad byte after the echo aborts; a fresh session then works.
    t0 = txq.size();
    e0 = err_cnt;
    send(8'h43);
    wait_tx(t0 + 1, "badS_echo_wait");
    send(8'h41);
    cyc(3);
    chk("badS_err", err_cnt - e0, 1);
    chk("badS_hold", core_hold, 0);
    chk("badS_notx", txq.size(), t0 + 1);
    pay_q = '{8'hAA, 8'h55, 8'hFF};
    session(32'h0000_1003, 1'b0, "after_badS");

    for (int s = 0; s < 10; s++) begin
      int n = $urandom_range(0, 22);
      send(8'h41 + 8'($urandom_range(0, 1)));
      pay_q = {};
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
      if (s == 9) for (int i = 0; i < n; i++) pay_q[i] = 8'hFF;
      session($urandom, ($urandom_range(0, 3) == 0), "rnd");
    end

    // Overrun: memory never acks, second word completes while the first is pending.
    ack_en = 1'b0;
    e0 = err_cnt;
    header(32'h4000_0000, 16'd12, "ovr", t0);
    for (int i = 0; i < 7; i++) send(8'(i));
    chk("ovr_early", err_cnt - e0, 0);
    chk("ovr_we_held", mem_we, 1);
    send(8'h07);
    cyc(2);
    chk("ovr_err", err_cnt - e0, 1);
    chk("ovr_we", mem_we, 0);
    chk("ovr_hold", core_hold, 0);
    cyc(10);
    chk("ovr_notx", txq.size(), t0 + 1);
    ack_en = 1'b1;

    // Timeout in ADDR.
    t0 = txq.size();
    e0 = err_cnt;
    send(8'h43);
    wait_tx(t0 + 1, "to_echo_wait");
    send(8'h53);
    send(8'h55);
    send(8'h12);
    send(8'h34);
    cyc(TO - 20);
    chk("to_early", err_cnt - e0, 0);
    cyc(40);
    chk("to_err", err_cnt - e0, 1);
    chk("to_hold", core_hold, 0);
    chk("to_notx", txq.size(), t0 + 1);

    // Reset mid-payload: no err, no further writes.
    e0 = err_cnt;
    header(32'h2000_0000, 16'd8, "midrst", t0);
    for (int i = 0; i < 5; i++) send(8'(i));
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    w0 = wq.size();
    cyc(10);
    chk("midrst_err", err_cnt - e0, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_hold", core_hold, 0);
    chk("midrst_nowr", wq.size(), w0);
    pay_q = '{8'h10, 8'h20};
    session(32'h2000_0000, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
